// File: rtl/cpu_int_pkg.sv
// Shared types and encodings for the CPU interrupt/call-injection controller.
package cpu_int_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_JUMP,
        S_WAIT,
        S_STOP
    } state_e;

    // Source ids double as arbitration priority: lower id wins.
    localparam logic [3:0] ID_RST  = 4'd0;
    localparam logic [3:0] ID_NMI  = 4'd1;
    localparam logic [3:0] ID_BRK  = 4'd2;
    localparam logic [3:0] ID_IRQ0 = 4'd3;
    localparam logic [3:0] ID_JSR  = 4'd14;
    localparam logic [3:0] ID_BSR  = 4'd15;

    localparam logic [15:0] PUSH_IR   = 16'h8322;
    localparam logic [15:0] PUSH_K    = 16'h0002;
    localparam logic [7:0]  JUMP_OP   = 8'h13;
    localparam logic [7:0]  JUMP_LO   = 8'h2C;

    localparam logic [15:0] DEF_RST_VEC      = 16'hFFFC;
    localparam logic [15:0] DEF_NMI_VEC      = 16'hFFFA;
    localparam logic [15:0] DEF_BRK_VEC      = 16'hFFF8;
    localparam logic [15:0] DEF_IRQ_VEC_BASE = 16'hFFE0;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: the lowest-index asserted request wins.
module int_prio_enc #(
    parameter int W   = 16,
    parameter int IDW = $clog2(W)
) (
    input  logic [W-1:0]   req_i,
    output logic [IDW-1:0] id_o,
    output logic           valid_o
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        id_o    = '0;
        valid_o = |req_i;
        for (int i = W - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/cpu_int_ctrl.sv
// Interrupt / call controller: arbitrates reset, NMI, BRK, IRQs, JSR and BSR and
// injects a push + jump instruction pair into decode.
module cpu_int_ctrl
    import cpu_int_pkg::*;
#(
    parameter int          N_IRQ        = 4,
    parameter logic [15:0] IRQ_VEC_BASE = DEF_IRQ_VEC_BASE,
    parameter logic [15:0] RST_VEC      = DEF_RST_VEC,
    parameter logic [15:0] NMI_VEC      = DEF_NMI_VEC,
    parameter logic [15:0] BRK_VEC      = DEF_BRK_VEC
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             rst,
    input  logic             nmi,
    input  logic             brk,
    input  logic             jsr,
    input  logic             bsr,
    input  logic             wai,
    input  logic             stp,
    input  logic             restore,
    input  logic [N_IRQ-1:0] irq,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             feed_ack,
    input  logic [7:0]       ir_low,
    output logic [15:0]      int_ir,
    output logic [15:0]      int_k,
    output logic             int_ack,
    output logic             replace_ir,
    output logic             replace_k,
    output logic             hold_fetch,
    output logic             hold_decode,
    output logic [3:0]       int_src,
    output logic             irq_masked
);

    state_e           state_q, state_d;
    logic [N_IRQ-1:0] mask_q;
    logic             irq_masked_q, nmi_pend_q, nmi_prev_q, pwr_q;
    logic [3:0]       src_q;
    logic [7:0]       ir_low_q;

    logic [N_IRQ-1:0] irq_en, irq_elig;
    logic [15:0]      req;
    logic [3:0]       arb_id;
    logic             arb_valid, accept, is_call;

    function automatic logic [15:0] vector_of(input logic [3:0] id);
        logic [3:0] line;
        line = id - ID_IRQ0;
        case (id)
            ID_RST:  return RST_VEC;
            ID_NMI:  return NMI_VEC;
            ID_BRK:  return BRK_VEC;
            default: return IRQ_VEC_BASE + {11'd0, line, 1'b0};
        endcase
    endfunction

    assign irq_en   = irq & mask_q;
    assign irq_elig = irq_en & {N_IRQ{~irq_masked_q}};

    // Which sources may compete depends on the state; rst always competes.
    always_comb begin
        req         = '0;
        req[ID_RST] = ~pwr_q | rst;
        case (state_q)
            S_IDLE: begin
                req[ID_NMI]            = nmi_pend_q;
                req[ID_BRK]            = brk;
                req[ID_IRQ0 +: N_IRQ]  = irq_elig;
                req[ID_JSR]            = jsr;
                req[ID_BSR]            = bsr;
            end
            S_WAIT: begin
                req[ID_NMI]            = nmi_pend_q;
                req[ID_IRQ0 +: N_IRQ]  = irq_elig;
            end
            default: ;
        endcase
    end

    int_prio_enc #(.W(16)) u_prio (
        .req_i   (req),
        .id_o    (arb_id),
        .valid_o (arb_valid)
    );

    // a_rst also gates the next state so every output is quiet while reset is held.
    assign accept = a_rst & arb_valid;

    always_comb begin
        state_d = state_q;
        if (!a_rst) begin
            state_d = S_IDLE;
        end else if (arb_valid) begin
            state_d = S_PUSH;
        end else begin
            case (state_q)
                S_IDLE:  state_d = wai ? S_WAIT : (stp ? S_STOP : S_IDLE);
                S_PUSH:  state_d = feed_ack ? S_JUMP : S_PUSH;
                S_JUMP:  state_d = feed_ack ? S_IDLE : S_JUMP;
                S_WAIT:  state_d = ((|irq_en) && irq_masked_q) ? S_IDLE : S_WAIT;
                default: state_d = state_q;
            endcase
        end
    end

    assign int_ack     = accept && (state_q != S_PUSH);
    assign hold_fetch  = (state_d != S_IDLE);
    assign hold_decode = hold_fetch;
    assign int_src     = accept ? arb_id : src_q;
    assign irq_masked  = irq_masked_q;
    assign is_call     = (src_q == ID_JSR) || (src_q == ID_BSR);

    always_comb begin
        int_ir     = 16'h0000;
        int_k      = 16'h0000;
        replace_ir = 1'b0;
        replace_k  = 1'b0;
        if (state_q == S_PUSH) begin
            int_ir     = PUSH_IR;
            int_k      = PUSH_K;
            replace_ir = 1'b1;
            replace_k  = 1'b1;
        end else if (state_q == S_JUMP) begin
            int_ir     = {JUMP_OP, (src_q == ID_JSR) ? ir_low_q : JUMP_LO};
            int_k      = is_call ? 16'h0000 : vector_of(src_q);
            replace_ir = (src_q != ID_BSR);
            replace_k  = ~is_call;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the pre-edge values together.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            irq_masked_q <= 1'b1;
            nmi_pend_q   <= 1'b0;
            nmi_prev_q   <= 1'b0;
            pwr_q        <= 1'b0;
            src_q        <= ID_RST;
            ir_low_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            pwr_q      <= 1'b1;
            nmi_prev_q <= nmi;
            // A fresh edge in the cycle NMI is taken re-arms the pending flag.
            nmi_pend_q <= (nmi_pend_q & ~(accept && (arb_id == ID_NMI))) | (nmi & ~nmi_prev_q);
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
            if (int_ack && (arb_id != ID_JSR) && (arb_id != ID_BSR)) begin
                irq_masked_q <= 1'b1;
            end else if (restore) begin
                irq_masked_q <= 1'b0;
            end
            if (accept) begin
                src_q    <= arb_id;
                ir_low_q <= ir_low;
            end
        end
    end

endmodule

// File: doc/cpu_int_ctrl.md
CPU_INT_CTRL -- requirements
Module: cpu_int_ctrl

Interface
REQ-001 SHALL have parameter N_IRQ, default 4, number of maskable IRQ lines (1..8).
REQ-002 SHALL have parameter IRQ_VEC_BASE, default 16'hFFE0; IRQ line i vector = IRQ_VEC_BASE + 2*i.
REQ-003 SHALL have parameters RST_VEC/NMI_VEC/BRK_VEC, defaults 16'hFFFC/16'hFFFA/16'hFFF8.
REQ-004 SHALL use one clock and an asynchronous active-low reset, ports as follows.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 a_rst  in  1  asynchronous active-low reset.
REQ-007 rst, nmi, brk, jsr, bsr, wai, stp, restore  in  1 each  sync reset request, NMI (edge), BRK/JSR/BSR/WAI/STP decode strobes, RTI restore.
REQ-008 irq  in  N_IRQ  level-sensitive IRQ lines; mask_we in 1, mask_wdata in N_IRQ  per-line mask write (1 = enabled).
REQ-009 feed_ack  in  1  decode consumed the injected instruction; ir_low in 8  JSR operand low byte.
REQ-010 int_ir out 16, int_k out 16, int_ack out 1, replace_ir out 1, replace_k out 1, hold_fetch out 1, hold_decode out 1, int_src out 4 (taken source id), irq_masked out 1 (global I flag).

Function
REQ-011 States SHALL be IDLE, PUSH, JUMP, WAIT, STOP.
REQ-012 Event priority SHALL be power-up > rst > NMI pending > brk > IRQ line 0 ... IRQ line N_IRQ-1 > jsr > bsr; id: 0 RST, 1 NMI, 2 BRK, 3+i IRQ i, 14 JSR, 15 BSR.
REQ-013 IRQ line i SHALL be eligible when irq[i] & mask[i] & ~irq_masked.
REQ-014 NMI SHALL be latched on rising edge into nmi_pend, cleared in the cycle NMI is taken; a new edge in that same cycle SHALL set it again.
REQ-015 IDLE: eligible event -> PUSH, latching source id and JSR/BSR kind; else wai -> WAIT; else stp -> STOP; else IDLE.
REQ-016 PUSH -> JUMP on feed_ack; JUMP -> IDLE on feed_ack; otherwise hold.
REQ-017 WAIT: rst/NMI pending/eligible IRQ -> PUSH; an irq line enabled in mask but blocked only by irq_masked -> IDLE; else hold.
REQ-018 STOP SHALL leave only on rst -> PUSH; NMI and IRQ ignored (NMI edge still latched).
REQ-019 rst SHALL be taken from any state, aborting PUSH/JUMP/WAIT/STOP into PUSH with id 0 the next cycle.
REQ-020 int_ack SHALL be high exactly in cycles whose next state is PUSH from a different state.
REQ-021 hold_fetch = hold_decode SHALL equal (next state in {PUSH, JUMP, WAIT, STOP}).
REQ-022 In PUSH: int_ir = 16'h8322, int_k = 16'h0002, replace_ir = replace_k = 1.
REQ-023 In JUMP: int_ir = {8'h13, JSR ? ir_low (captured at entry) : 8'h2C}; int_k = vector of source; replace_ir = ~BSR; replace_k = 1 for interrupt sources (ids 0..2+N_IRQ), 0 for JSR/BSR.
REQ-024 Outside PUSH/JUMP, replace_ir = replace_k = 0 and int_ir = int_k = 16'h0000.
REQ-025 irq_masked SHALL set on int_ack for interrupt sources (not JSR/BSR) and clear on restore; simultaneous set and clear -> set wins.
REQ-026 mask_we SHALL load the mask register in one cycle; a write in the same cycle as arbitration affects the next cycle only.
REQ-027 Vector arithmetic SHALL be 16-bit, wrap-free by parameter legality (IRQ_VEC_BASE + 2*(N_IRQ-1) <= 16'hFFF6).

Reset
REQ-028 On a_rst low: state IDLE, mask all-zero, irq_masked 1, nmi_pend 0, powerup flag 0, captured id/ir_low 0; all outputs 0.
REQ-029 First cycle after reset release SHALL take the power-up event (id 0, RST_VEC) regardless of inputs, then set powerup flag.

Structure
REQ-030 Package cpu_int_pkg SHALL hold the state enum, source-id constants, 16'h8322/8'h13/8'h2C encodings and default vectors.
REQ-031 Arbitration SHALL be a sub-module int_prio_enc (one-hot request vector in, id + valid out, combinational).

Verification
REQ-032 Reset release, feed_ack every cycle -> int_ack cycle 1, PUSH int_ir 16'h8322/int_k 16'h0002, JUMP int_k 16'hFFFC, IDLE after 3 cycles.
REQ-033 mask=4'b0110, irq=4'b0110, irq_masked 0 -> int_src 4, int_k 16'hFFE2; irq_masked=1 after; restore -> line 2 taken, int_k 16'hFFE4.
REQ-034 NMI edge plus brk and irq[0] same cycle -> NMI first (16'hFFFA); after restore, BRK (16'hFFF8) before IRQ 0.
REQ-035 jsr with ir_low 8'h5A -> JUMP int_ir 16'h135A, replace_k 0; bsr -> replace_ir 0 in JUMP, irq_masked unchanged.
REQ-036 stp, then irq[0] and NMI edge -> stays STOP, holds asserted; rst -> PUSH, RST_VEC.
REQ-037 wai with irq_masked 1, enabled irq[1] rises -> IDLE, no int_ack; with irq_masked 0 -> PUSH, int_k 16'hFFE2.
